// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: drives DSP48A1 control pins so the slice streams P = sum A[i]*B[i].
// Define DSP_MAC_BIAS_EN to add a C-port bias preload (BIAS_LD/CEC).
module dsp_mac_sequencer #(
    parameter int         LEN_W     = 16,
    parameter logic [7:0] OPM_FIRST = 8'h01,
    parameter logic [7:0] OPM_ACC   = 8'h09
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [LEN_W-1:0] LEN,
    output logic             BUSY,
    input  logic             S_VALID,
    output logic             S_READY,
    output logic [7:0]       OPMODE,
    output logic             CEOPMODE,
    output logic             CEA,
    output logic             CEB,
    output logic             CEM,
    output logic             CEP,
    output logic             DSP_RST,
`ifdef DSP_MAC_BIAS_EN
    input  logic             BIAS_LD,
    output logic             CEC,
`endif
    output logic             DONE,
    output logic [LEN_W-1:0] REMAIN
);
    typedef enum logic [1:0] {IDLE, RUN, ZERO, DRAIN} state_t;
    state_t     state, nxt;
    logic [1:0] ph;
    logic       first, acc, accept;
    logic [7:0] first_op, zero_op;

`ifdef DSP_MAC_BIAS_EN
    logic bias;
    always_ff @(posedge CLK)
        if (RST) bias <= 1'b0;
        else if (accept) bias <= BIAS_LD;
    assign CEC      = accept & BIAS_LD;
    assign first_op = bias ? 8'h0D : OPM_FIRST;
    assign zero_op  = BIAS_LD ? 8'h0C : 8'h00;
`else
    assign first_op = OPM_FIRST;
    assign zero_op  = 8'h00;
`endif

    assign BUSY     = state != IDLE;
    assign S_READY  = state == RUN;
    assign CEA      = acc;
    assign CEB      = acc;
    assign CEOPMODE = 1'b1;
    assign DSP_RST  = RST;
    // ZERO and DRAIN both last three cycles; the third carries DONE
    assign DONE     = (state == ZERO || state == DRAIN) && ph == 2'd2;

    always_comb begin
        acc    = S_VALID & S_READY;
        accept = (state == IDLE) & START;
        nxt    = state;
        case (state)
            IDLE:    if (START) nxt = (LEN == '0) ? ZERO : RUN;
            RUN:     if (acc && REMAIN == LEN_W'(1)) nxt = DRAIN;
            default: if (ph == 2'd2) nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            ph     <= 2'd0;
            first  <= 1'b0;
            OPMODE <= 8'h00;
            CEM    <= 1'b0;
            CEP    <= 1'b0;
            REMAIN <= '0;
        end else begin
            state <= nxt;
            ph    <= (state == ZERO || state == DRAIN) ? ph + 2'd1 : 2'd0;
            CEM   <= acc;
            // the LEN=0 flush loads P with the zero/C-only OPMODE set at START
            CEP   <= CEM | (state == ZERO && ph == 2'd0);
            if (accept) begin
                REMAIN <= LEN;
                first  <= 1'b1;
                if (LEN == '0) OPMODE <= zero_op;
            end else if (acc) begin
                REMAIN <= REMAIN - LEN_W'(1);
                first  <= 1'b0;
                OPMODE <= first ? first_op : OPM_ACC;
            end
        end
    end
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer: event-scheduled model of the sequencer plus a behavioural DSP48A1 slice.
// Define DSP_MAC_BIAS_EN to also exercise the C-port bias preload.
module tb_dsp_mac_sequencer;
    localparam int LW = 16;
    localparam int N  = 1024;

    logic          CLK = 1'b0, RST = 1'b1, START = 1'b0, S_VALID = 1'b0;
    logic [LW-1:0] LEN = '0;
    logic          BUSY, S_READY, CEOPMODE, CEA, CEB, CEM, CEP, DSP_RST, DONE;
    logic [7:0]    OPMODE;
    logic [LW-1:0] REMAIN;
    logic          bias_w = 1'b0;
    logic          cec_w;

    logic signed [17:0] a_in = '0, b_in = '0, a1, b1;
    logic [47:0]        c_in = '0, m, p, c_reg;
    logic [7:0]         opm_reg;

    int total = 0, bad = 0;

    always #5 CLK = ~CLK;

`ifdef DSP_MAC_BIAS_EN
    logic CEC;
    assign cec_w = CEC;
`else
    assign cec_w = 1'b0;
`endif

    dsp_mac_sequencer #(.LEN_W(LW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .LEN(LEN), .BUSY(BUSY),
        .S_VALID(S_VALID), .S_READY(S_READY), .OPMODE(OPMODE), .CEOPMODE(CEOPMODE),
        .CEA(CEA), .CEB(CEB), .CEM(CEM), .CEP(CEP), .DSP_RST(DSP_RST),
`ifdef DSP_MAC_BIAS_EN
        .BIAS_LD(bias_w), .CEC(CEC),
`endif
        .DONE(DONE), .REMAIN(REMAIN)
    );

    // slice with A1/B1, M, OPMODE, C and P registers, synchronous reset
    always @(posedge CLK) begin
        if (DSP_RST) begin
            a1 <= '0; b1 <= '0; m <= '0; p <= '0; c_reg <= '0; opm_reg <= '0;
        end else begin
            if (CEA) a1 <= a_in;
            if (CEB) b1 <= b_in;
            if (CEM) m <= 48'(a1) * 48'(b1);
            if (CEOPMODE) opm_reg <= OPMODE;
            if (cec_w) c_reg <= c_in;
            if (CEP) p <= ((opm_reg[1:0] == 2'b01) ? m : 48'd0) +
                          ((opm_reg[3:2] == 2'b10) ? p : (opm_reg[3:2] == 2'b11) ? c_reg : 48'd0);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, expv);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got timeout want event", nm);
    endtask

    // model: job bookkeeping plus per-cycle schedules of the pulses a job must emit
    logic          exp_cem [N], exp_cep [N], exp_done [N];
    logic          m_busy = 1'b0, m_run = 1'b0, m_first = 1'b0, m_bias = 1'b0;
    logic [LW-1:0] m_remain = '0;
    logic [7:0]    exp_op = 8'h00;
    int            cyc = 0, cep_cnt = 0, done_cnt = 0, mi;
    bit            mon_en = 1'b0;

    always @(negedge CLK) if (mon_en) begin
        mi = cyc % N;
        chk("busy", BUSY, m_busy);
        chk("s_ready", S_READY, m_run);
        chk("cea", CEA, S_VALID & m_run);
        chk("ceb", CEB, S_VALID & m_run);
        chk("cem", CEM, exp_cem[mi]);
        chk("cep", CEP, exp_cep[mi]);
        chk("done", DONE, exp_done[mi]);
        chk("opmode", OPMODE, exp_op);
        chk("remain", REMAIN, m_remain);
        chk("dsp_rst", DSP_RST, RST);
        chk("ceopmode", CEOPMODE, 1'b1);
`ifdef DSP_MAC_BIAS_EN
        chk("cec", CEC, !m_busy && START && bias_w);
`endif
        cep_cnt  += int'(CEP);
        done_cnt += int'(DONE);
        if (RST) begin
            m_busy = 0; m_run = 0; m_first = 0; m_remain = '0; exp_op = 8'h00;
            for (int k = 0; k < N; k++) begin
                exp_cem[k] = 0; exp_cep[k] = 0; exp_done[k] = 0;
            end
        end else begin
            if (!m_busy && START) begin
                m_busy = 1;
                if (LEN != '0) begin
                    m_run = 1; m_remain = LEN; m_first = 1; m_bias = bias_w;
                end else begin
                    exp_op = bias_w ? 8'h0C : 8'h00;
                    exp_cep[(cyc + 2) % N]  = 1;
                    exp_done[(cyc + 3) % N] = 1;
                end
            end else if (m_run && S_VALID) begin
                exp_cem[(cyc + 1) % N] = 1;
                exp_cep[(cyc + 2) % N] = 1;
                exp_op   = m_first ? (m_bias ? 8'h0D : 8'h01) : 8'h09;
                m_first  = 0;
                m_remain = m_remain - 1'b1;
                if (m_remain == '0) begin
                    m_run = 0;
                    exp_done[(cyc + 3) % N] = 1;
                end
            end
            if (exp_done[mi]) m_busy = 0;
            exp_cem[mi] = 0; exp_cep[mi] = 0; exp_done[mi] = 0;
        end
        cyc++;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic start_job(input int len, input bit bias);
        LEN = LW'(len); START = 1; bias_w = bias;
        tick;
        START = 0; bias_w = 0;
    endtask

    task automatic send(input int a, input int b, input int gap);
        int n = 0;
        a_in = 18'(a); b_in = 18'(b); S_VALID = 1;
        while (!S_READY && n < 20) begin tick; n++; end
        if (n >= 20) timeout("ready_wait");
        tick;
        if (gap > 0) begin
            S_VALID = 0;
            repeat (gap) tick;
        end
    endtask

    // returns DONE latency counted from the current cycle as 1, plus P and REMAIN seen then
    task automatic wait_done(output int lat, output logic [47:0] pv, output logic [LW-1:0] rv);
        lat = 0; pv = '0; rv = '0;
        for (int k = 1; k <= 20; k++) begin
            if (DONE) begin lat = k; pv = p; rv = REMAIN; break; end
            tick;
        end
        if (lat == 0) timeout("done_wait");
        tick;
    endtask

    int lat;
    logic [47:0] pv;
    logic [LW-1:0] rv;

    initial begin
        for (int k = 0; k < N; k++) begin exp_cem[k] = 0; exp_cep[k] = 0; exp_done[k] = 0; end
        repeat (2) tick;
        mon_en = 1;
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_ready", S_READY, 1'b0);
        chk("rst_opmode", OPMODE, 8'h00);
        chk("rst_cem", CEM, 1'b0);
        chk("rst_cep", CEP, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_remain", REMAIN, 16'd0);
        RST = 0;
        tick;

        start_job(4, 0);
        send(1, 5, 0); send(2, 6, 0); send(3, 7, 0); send(4, 8, 0);
        S_VALID = 0;
        wait_done(lat, pv, rv);
        chk("t1_lat", lat, 3);
        chk("t1_p", pv, 48'd70);
        chk("t1_remain", rv, 16'd0);

        cep_cnt = 0; done_cnt = 0;
        start_job(3, 0);
        send(-3, 100, 2); send(-3, 100, 2); send(-3, 100, 0);
        S_VALID = 0;
        wait_done(lat, pv, rv);
        chk("t2_p", pv, 48'hFFFF_FFFF_FC7C);
        repeat (3) tick;
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_cep_cnt", cep_cnt, 3);

        cep_cnt = 0;
        start_job(0, 0);
        chk("t3_opmode", OPMODE, 8'h00);
        wait_done(lat, pv, rv);
        chk("t3_lat", lat, 3);
        chk("t3_p", pv, 48'd0);
        chk("t3_cep_cnt", cep_cnt, 1);

        start_job(5, 0);
        send(1, 1, 0); send(2, 2, 0);
        S_VALID = 0; RST = 1;
        done_cnt = 0;
        tick;
        RST = 0;
        chk("t4_busy", BUSY, 1'b0);
        repeat (6) tick;
        chk("t4_no_done", done_cnt, 0);
        start_job(1, 0);
        send(2, 2, 0);
        S_VALID = 0;
        wait_done(lat, pv, rv);
        chk("t4_p", pv, 48'd4);

        start_job(2, 0);
        send(1, 1, 0);
        S_VALID = 0; START = 1; LEN = 16'd7;
        tick;
        START = 0;
        send(2, 3, 0);
        S_VALID = 0;
        wait_done(lat, pv, rv);
        chk("t5_p", pv, 48'd7);
        chk("t5_remain", rv, 16'd0);
        start_job(1, 0);
        chk("t5_b2b_busy", BUSY, 1'b1);
        send(9, 9, 0);
        S_VALID = 0;
        wait_done(lat, pv, rv);
        chk("t5_p2", pv, 48'd81);

`ifdef DSP_MAC_BIAS_EN
        c_in = 48'd1000;
        start_job(2, 1);
        send(1, 2, 0); send(1, 3, 0);
        S_VALID = 0;
        wait_done(lat, pv, rv);
        chk("bias_p", pv, 48'd1005);
        start_job(0, 1);
        wait_done(lat, pv, rv);
        chk("bias_zero_p", pv, 48'd1000);
`endif

        repeat (4) tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end
endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
- Control sequencer that runs the DSP48A1 slice as a streaming multiply-accumulate engine: P = sum over i of A[i]*B[i], for a vector of LEN samples.
- Sample data goes straight from the source to the slice A/B inputs. This block only gates the data with a valid/ready handshake and drives the slice control inputs: OPMODE, the clock enables and the resets.
- The drive timing matches the slice's default pipeline: A0REG=0, B0REG=0, A1REG=1, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, B_INPUT="DIRECT", RSTTYPE="SYNC".
- It raises a single-cycle DONE when P holds the final sum.

Parameters:
- LEN_W, 16, width of the vector length input and the internal sample counter.
- OPM_FIRST, 8'h01, OPMODE for the first product: X=M, Z=0, add, pre-adder bypassed.
- OPM_ACC, 8'h09, OPMODE for later products: X=M, Z=P, add.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- START  in  1  starts a job; sampled only in IDLE.
- LEN  in  LEN_W  number of samples; captured when START is accepted.
- BUSY  out  1  high in every state except IDLE.
- S_VALID  in  1  source has an A/B sample on the slice inputs.
- S_READY  out  1  high only in RUN.
- OPMODE  out  8  registered; wired to the slice OPMODE input.
- CEOPMODE  out  1  constant 1.
- CEA, CEB  out  1  combinational, equal to ACC (ACC = S_VALID & S_READY).
- CEM  out  1  registered; ACC delayed by 1 cycle.
- CEP  out  1  registered; ACC delayed by 2 cycles, or the LEN=0 flush pulse.
- DSP_RST  out  1  equal to RST; drives RSTA, RSTB, RSTM, RSTP, RSTOPMODE and RSTCARRYIN.
- DONE  out  1  one-cycle pulse when P is final.
- REMAIN  out  LEN_W  samples still to be accepted.

Behaviour:
- Reset, and RST asserted at any point including mid-job:
  - State goes to IDLE.
  - OPMODE=0, CEM=0, CEP=0, DONE=0, REMAIN=0, S_READY=0.
  - DSP_RST clears the slice in the same cycle.
  - The job in flight is discarded; no DONE is produced.
- States: IDLE, RUN, ZERO, DRAIN.
- IDLE:
  - START with LEN>0: capture REMAIN=LEN, set the first-sample flag, go to RUN.
  - START with LEN=0: go to ZERO.
- RUN, on each cycle with ACC=1:
  - REMAIN decrements.
  - OPMODE register loads OPM_FIRST if the first-sample flag is set, else OPM_ACC; the flag then clears.
  - When REMAIN was 1 on that cycle, go to DRAIN.
- RUN, on cycles with S_VALID=0:
  - OPMODE holds; no enables are produced.
  - Bubbles of any length are allowed between samples.
- Alignment for a sample accepted in cycle t:
  - A1/B1 capture at edge t+1.
  - CEM is high in cycle t+1; M captures at edge t+2.
  - OPMODE output is valid in cycle t+1; the slice registers it at edge t+2.
  - CEP is high in cycle t+2; P captures at edge t+3.
- DRAIN: with the last sample accepted at t, DONE=1 in cycle t+3 and the state returns to IDLE in that same cycle.
- ZERO (LEN=0):
  - Cycle 1: OPMODE=8'h00.
  - Cycle 2: CEP=1, so P loads 0.
  - Cycle 3: DONE=1, return to IDLE.
- START while BUSY is ignored; LEN is not resampled.
- START is accepted again in the cycle after DONE. Back-to-back jobs are legal, and the trailing CEM/CEP of the previous job still complete.
- Arithmetic and width:
  - The slice sign-extends the 36-bit product to 48 bits.
  - Accumulation wraps modulo 2^48; this block adds no overflow detection.

Optional Feature:
- Macro DSP_MAC_BIAS_EN.
- Defined:
  - Adds output CEC (1 bit) and input BIAS_LD (1 bit, sampled with START).
  - If BIAS_LD=1, CEC pulses in the START cycle and the first OPMODE becomes 8'h0D (Z=C), so P = C + sum.
  - For LEN=0 with BIAS_LD=1, the flush OPMODE becomes 8'h0C, so P = C.
- Not defined: no CEC or BIAS_LD ports, and behaviour is exactly as above.

Test Plan:
- LEN=4, A={1,2,3,4}, B={5,6,7,8}, S_VALID held high -> DONE exactly 3 cycles after the 4th accept, P=70, REMAIN=0.
- LEN=3, A=-3, B=100 with 2-cycle bubbles between samples -> P=-900 (48'hFFFF_FFFF_FC7C), DONE once, CEP high exactly 3 times.
- LEN=0 START -> OPMODE=00, one CEP pulse, P=0, DONE 3 cycles after START.
- RST asserted after the 2nd of 5 samples -> DONE never pulses, BUSY=0 next cycle; a new LEN=1 job, A=2, B=2, gives P=4.
- START pulsed during a LEN=2 job -> ignored; then a second job with START the cycle after DONE, LEN=1, A=B=9 -> P=81, with no accumulation carried over from the previous result.
- With DSP_MAC_BIAS_EN defined: BIAS_LD=1, C=1000, LEN=2, A={1,1}, B={2,3} -> P=1005.
